// File: rtl/uart_word_sender_if.sv
// ---------------------------------------------------------------------------
// uart_word_sender_if
// Purpose: valid/ready character channel between the word sender and the
//          UART transmitter.
// Signals:
//   tx_data   8  ASCII character offered to the UART TX
//   tx_valid  1  tx_data holds a character waiting to be taken
//   tx_ready  1  UART TX takes tx_data in a cycle where tx_valid is also high
// Modports:
//   master  the word sender (drives data/valid, observes ready)
//   slave   the UART TX (observes data/valid, drives ready)
// ---------------------------------------------------------------------------
interface uart_word_sender_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_word_sender.sv
// ---------------------------------------------------------------------------
// uart_word_sender
// Purpose: turns a 32-bit word from the monitor logic into eight uppercase
//          ASCII hex characters, followed either by a separator or by CR/LF.
//          The characters go to the UART TX over a valid/ready channel.
//          Once the whole word and its trailer have been taken,
//          o_flushing_wq pulses for one cycle so the dump state machine can
//          move on.
// Parameters:
//   WORDS_PER_LINE  words per output line before CR/LF (1..255)
//   SEP_CHAR        character sent after a word that does not end a line
// Ports:
//   clk                clock
//   rst_n              asynchronous active-low reset
//   i_rdata_snd_start  start pulse, only honoured while idle
//   i_rdata_snd        word to send, captured on an accepted start
//   i_crlf_force       captured with start: end this word with CR/LF
//   i_line_clr         clears the words-per-line counter
//   tx                 character channel to the UART TX (master side)
//   o_flushing_wq      1-cycle pulse once word and trailer are accepted
//   o_busy             high whenever the sender is not idle
// ---------------------------------------------------------------------------
module uart_word_sender #(
  parameter int         WORDS_PER_LINE = 4,
  parameter logic [7:0] SEP_CHAR       = 8'h20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_rdata_snd_start,
  input  logic [31:0]               i_rdata_snd,
  input  logic                      i_crlf_force,
  input  logic                      i_line_clr,
  uart_word_sender_if.master        tx,
  output logic                      o_flushing_wq,
  output logic                      o_busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEX,
    ST_SEP,
    ST_CR,
    ST_LF,
    ST_DONE
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(WORDS_PER_LINE - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_word;
  logic        r_force;
  logic [2:0]  r_nib_cnt;
  logic [2:0]  w_nib_nxt;
  logic [7:0]  r_word_cnt;
  logic [7:0]  w_word_cnt_nxt;
  logic [7:0]  r_tx_data;
  logic [7:0]  w_tx_data_nxt;
  logic        r_tx_valid;
  logic        w_tx_valid_nxt;
  logic        r_flush;
  logic        w_flush_nxt;
  logic        w_latch;
  logic        w_accept;
  logic [2:0]  w_nib_inc;
  logic [31:0] w_word_shift;
  logic [7:0]  w_cnt_seen;
  logic        w_line_end;

  // Nibble to ASCII: 0-9 map onto '0'-'9', A-F onto 'A'-'F'.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  assign w_accept     = r_tx_valid & tx.tx_ready;
  assign w_nib_inc    = r_nib_cnt + 3'd1;
  // Moves the next nibble to be sent into the top four bits.
  assign w_word_shift = r_word << {w_nib_inc, 2'b00};
  // A line clear in the same cycle as the end-of-line decision is honoured.
  assign w_cnt_seen   = i_line_clr ? 8'd0 : r_word_cnt;
  assign w_line_end   = r_force | (w_cnt_seen == LAST_CNT);

  // The next character and tx_valid are computed here and registered below.
  // This keeps tx_valid a flop output while still allowing one character
  // per cycle when the UART is always ready.
  always_comb begin
    w_state_nxt    = r_state;
    w_nib_nxt      = r_nib_cnt;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_flush_nxt    = 1'b0;
    w_latch        = 1'b0;
    w_word_cnt_nxt = i_line_clr ? 8'd0 : r_word_cnt;

    case (r_state)
      ST_IDLE: begin
        if (i_rdata_snd_start) begin
          w_latch        = 1'b1;
          w_nib_nxt      = 3'd0;
          w_tx_data_nxt  = hex_char(i_rdata_snd[31:28]);
          w_tx_valid_nxt = 1'b1;
          w_state_nxt    = ST_HEX;
        end
      end
      ST_HEX: begin
        if (w_accept) begin
          if (r_nib_cnt == 3'd7) begin
            if (w_line_end) begin
              w_tx_data_nxt = 8'h0D;
              w_state_nxt   = ST_CR;
            end else begin
              w_tx_data_nxt = SEP_CHAR;
              w_state_nxt   = ST_SEP;
            end
          end else begin
            w_nib_nxt     = w_nib_inc;
            w_tx_data_nxt = hex_char(w_word_shift[31:28]);
          end
        end
      end
      ST_SEP: begin
        if (w_accept) begin
          if (!i_line_clr) w_word_cnt_nxt = r_word_cnt + 8'd1;
          w_tx_data_nxt  = 8'h00;
          w_tx_valid_nxt = 1'b0;
          w_flush_nxt    = 1'b1;
          w_state_nxt    = ST_DONE;
        end
      end
      ST_CR: begin
        if (w_accept) begin
          w_tx_data_nxt = 8'h0A;
          w_state_nxt   = ST_LF;
        end
      end
      ST_LF: begin
        if (w_accept) begin
          w_word_cnt_nxt = 8'd0;
          w_tx_data_nxt  = 8'h00;
          w_tx_valid_nxt = 1'b0;
          w_flush_nxt    = 1'b1;
          w_state_nxt    = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_tx_valid_nxt = 1'b0;
        w_state_nxt    = ST_IDLE;
      end
    endcase
  end

  // State and output registers. A reset mid-word drops the partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_word     <= 32'd0;
      r_force    <= 1'b0;
      r_nib_cnt  <= 3'd0;
      r_word_cnt <= 8'd0;
      r_tx_data  <= 8'd0;
      r_tx_valid <= 1'b0;
      r_flush    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_nib_cnt  <= w_nib_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_flush    <= w_flush_nxt;
      if (w_latch) begin
        r_word  <= i_rdata_snd;
        r_force <= i_crlf_force;
      end
    end
  end

  assign tx.tx_data    = r_tx_data;
  assign tx.tx_valid   = r_tx_valid;
  assign o_flushing_wq = r_flush;
  assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_word_sender.sv
// ---------------------------------------------------------------------------
// tb_uart_word_sender
// Purpose: directed testbench for uart_word_sender with WORDS_PER_LINE=4 and
//          a space separator. Each scenario task drives its own stimulus and
//          compares the results against hand-computed character sequences
//          and cycle numbers.
// ---------------------------------------------------------------------------
module tb_uart_word_sender;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rdataSndStart = 1'b0;
  logic [31:0] rdataSnd = 32'd0;
  logic        crlfForce = 1'b0;
  logic        lineClr = 1'b0;
  logic        flushingWq;
  logic        busy;

  uart_word_sender_if txIf();

  uart_word_sender #(.WORDS_PER_LINE(4), .SEP_CHAR(8'h20)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_rdata_snd_start (rdataSndStart),
    .i_rdata_snd       (rdataSnd),
    .i_crlf_force      (crlfForce),
    .i_line_clr        (lineClr),
    .tx                (txIf.master),
    .o_flushing_wq     (flushingWq),
    .o_busy            (busy)
  );

  always #5 clk = ~clk;

  int vecCount = 0;
  int errCount = 0;
  int cyc = 0;
  int flushCount = 0;
  int lastFlushCyc = 0;
  int startCyc = 0;
  int rxBase = 0;
  int flushBase = 0;
  logic [7:0] rxQ[$];
  int xferCyc[$];

  // Records every accepted character, the edge it was taken on, and every
  // flushing_wq pulse. Edge numbers match startCyc numbering below.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (txIf.tx_valid === 1'b1 && txIf.tx_ready === 1'b1) begin
      rxQ.push_back(txIf.tx_data);
      xferCyc.push_back(cyc + 1);
    end
    if (flushingWq === 1'b1) begin
      flushCount   <= flushCount + 1;
      lastFlushCyc <= cyc + 1;
    end
  end

  // One-cycle start pulse; the inputs are scrambled afterwards so a late
  // sample of them would show up in the characters.
  task automatic startWord(input logic [31:0] w, input logic f);
    @(negedge clk);
    rdataSndStart = 1'b1;
    rdataSnd      = w;
    crlfForce     = f;
    startCyc      = cyc + 1;
    rxBase        = rxQ.size();
    flushBase     = flushCount;
    @(negedge clk);
    rdataSndStart = 1'b0;
    rdataSnd      = ~w;
    crlfForce     = ~f;
  endtask

  // Waits (bounded) for the flush pulse of the word last started.
  task automatic waitFlush(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (flushCount != flushBase) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic clearLine();
    @(negedge clk);
    lineClr = 1'b1;
    @(negedge clk);
    lineClr = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    vecCount++; if (txIf.tx_valid !== 1'b0) begin errCount++; $display("[TB] FAIL reset_tx_valid: got %b expected 0", txIf.tx_valid); end
    vecCount++; if (txIf.tx_data !== 8'h00) begin errCount++; $display("[TB] FAIL reset_tx_data: got %h expected 00", txIf.tx_data); end
    vecCount++; if (flushingWq !== 1'b0) begin errCount++; $display("[TB] FAIL reset_flush: got %b expected 0", flushingWq); end
    vecCount++; if (busy !== 1'b0) begin errCount++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    vecCount++; if (dut.r_word_cnt !== 8'd0) begin errCount++; $display("[TB] FAIL reset_word_cnt: got %0d expected 0", dut.r_word_cnt); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] exp[$];
    bit ok;
    exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h20};
    txIf.tx_ready = 1'b1;
    startWord(32'h1234ABCD, 1'b0);
    vecCount++; if (busy !== 1'b1 || txIf.tx_valid !== 1'b1) begin errCount++; $display("[TB] FAIL single_busy_valid: got %b%b expected 11", busy, txIf.tx_valid); end
    waitFlush(ok);
    vecCount++; if (!ok) begin errCount++; $display("[TB] FAIL single_flush_timeout: got none expected pulse"); end
    vecCount++; if (rxQ.size() - rxBase != exp.size()) begin errCount++; $display("[TB] FAIL single_count: got %0d expected %0d", rxQ.size() - rxBase, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      vecCount++;
      if (rxBase + i >= rxQ.size()) begin errCount++; $display("[TB] FAIL single_char%0d: got none expected %h", i, exp[i]); end
      else if (rxQ[rxBase + i] !== exp[i]) begin errCount++; $display("[TB] FAIL single_char%0d: got %h expected %h", i, rxQ[rxBase + i], exp[i]); end
    end
    vecCount++; if (xferCyc.size() <= rxBase || xferCyc[rxBase] != startCyc + 1) begin errCount++; $display("[TB] FAIL single_first_char_cycle: got offset %0d expected 1", (xferCyc.size() > rxBase) ? xferCyc[rxBase] - startCyc : -1); end
    vecCount++; if (lastFlushCyc != startCyc + 10) begin errCount++; $display("[TB] FAIL single_flush_cycle: got offset %0d expected 10", lastFlushCyc - startCyc); end
    vecCount++; if (dut.r_word_cnt !== 8'd1) begin errCount++; $display("[TB] FAIL single_word_cnt: got %0d expected 1", dut.r_word_cnt); end
  endtask

  task automatic test_line_clr();
    bit ok;
    clearLine();
    vecCount++; if (dut.r_word_cnt !== 8'd0) begin errCount++; $display("[TB] FAIL line_clr_idle: got %0d expected 0", dut.r_word_cnt); end
    startWord(32'h00000000, 1'b0);
    waitFlush(ok);
    vecCount++; if (!ok || dut.r_word_cnt !== 8'd1) begin errCount++; $display("[TB] FAIL line_clr_pre_cnt: got %0d expected 1", dut.r_word_cnt); end
    // Second word: raise line_clr exactly in the cycle the separator is taken.
    startWord(32'h11111111, 1'b0);
    repeat (8) @(negedge clk);
    vecCount++; if (txIf.tx_valid !== 1'b1 || txIf.tx_data !== 8'h20) begin errCount++; $display("[TB] FAIL line_clr_sep_present: got %b/%h expected 1/20", txIf.tx_valid, txIf.tx_data); end
    lineClr = 1'b1;
    @(negedge clk);
    lineClr = 1'b0;
    waitFlush(ok);
    vecCount++; if (!ok || dut.r_word_cnt !== 8'd0) begin errCount++; $display("[TB] FAIL line_clr_vs_sep: got %0d expected 0", dut.r_word_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[$];
    bit ok;
    for (int w = 0; w < 4; w++) begin
      exp = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30};
      exp.push_back(8'h30 + 8'(w));
      if (w == 3) begin exp.push_back(8'h0D); exp.push_back(8'h0A); end
      else exp.push_back(8'h20);
      startWord(32'(w), 1'b0);
      waitFlush(ok);
      vecCount++; if (!ok) begin errCount++; $display("[TB] FAIL b2b_flush_timeout_w%0d: got none expected pulse", w); end
      vecCount++; if (rxQ.size() - rxBase != exp.size()) begin errCount++; $display("[TB] FAIL b2b_count_w%0d: got %0d expected %0d", w, rxQ.size() - rxBase, exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
        vecCount++;
        if (rxBase + i >= rxQ.size()) begin errCount++; $display("[TB] FAIL b2b_w%0d_char%0d: got none expected %h", w, i, exp[i]); end
        else if (rxQ[rxBase + i] !== exp[i]) begin errCount++; $display("[TB] FAIL b2b_w%0d_char%0d: got %h expected %h", w, i, rxQ[rxBase + i], exp[i]); end
      end
      vecCount++; if (lastFlushCyc != startCyc + ((w == 3) ? 11 : 10)) begin errCount++; $display("[TB] FAIL b2b_flush_cycle_w%0d: got offset %0d expected %0d", w, lastFlushCyc - startCyc, (w == 3) ? 11 : 10); end
    end
    vecCount++; if (dut.r_word_cnt !== 8'd0) begin errCount++; $display("[TB] FAIL b2b_word_cnt: got %0d expected 0", dut.r_word_cnt); end
  endtask

  task automatic test_force();
    logic [7:0] exp[$];
    bit ok;
    startWord(32'h89ABCDEF, 1'b0);
    waitFlush(ok);
    vecCount++; if (!ok || dut.r_word_cnt !== 8'd1) begin errCount++; $display("[TB] FAIL force_pre_cnt: got %0d expected 1", dut.r_word_cnt); end
    exp = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    startWord(32'hDEADBEEF, 1'b1);
    waitFlush(ok);
    vecCount++; if (!ok) begin errCount++; $display("[TB] FAIL force_flush_timeout: got none expected pulse"); end
    vecCount++; if (rxQ.size() - rxBase != exp.size()) begin errCount++; $display("[TB] FAIL force_count: got %0d expected %0d", rxQ.size() - rxBase, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      vecCount++;
      if (rxBase + i >= rxQ.size()) begin errCount++; $display("[TB] FAIL force_char%0d: got none expected %h", i, exp[i]); end
      else if (rxQ[rxBase + i] !== exp[i]) begin errCount++; $display("[TB] FAIL force_char%0d: got %h expected %h", i, rxQ[rxBase + i], exp[i]); end
    end
    vecCount++; if (lastFlushCyc != startCyc + 11) begin errCount++; $display("[TB] FAIL force_flush_cycle: got offset %0d expected 11", lastFlushCyc - startCyc); end
    vecCount++; if (dut.r_word_cnt !== 8'd0) begin errCount++; $display("[TB] FAIL force_word_cnt: got %0d expected 0", dut.r_word_cnt); end
  endtask

  task automatic test_stall();
    logic [7:0] exp[$];
    logic [7:0] prevData;
    bit prevStall;
    bit done;
    exp = '{8'h30, 8'h46, 8'h30, 8'h46, 8'h30, 8'h46, 8'h30, 8'h46, 8'h20};
    clearLine();
    txIf.tx_ready = 1'b0;
    startWord(32'h0F0F0F0F, 1'b0);
    prevStall = 1'b0;
    prevData  = 8'h00;
    done      = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (prevStall) begin
        vecCount++;
        if (txIf.tx_valid !== 1'b1 || txIf.tx_data !== prevData) begin
          errCount++;
          $display("[TB] FAIL stall_hold: got %b/%h expected 1/%h", txIf.tx_valid, txIf.tx_data, prevData);
        end
      end
      if (flushCount != flushBase) begin
        done = 1'b1;
        break;
      end
      txIf.tx_ready = (i == 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
      prevStall = (txIf.tx_valid === 1'b1) && !txIf.tx_ready;
      prevData  = txIf.tx_data;
      @(negedge clk);
    end
    txIf.tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    vecCount++; if (!done) begin errCount++; $display("[TB] FAIL stall_flush_timeout: got none expected pulse"); end
    vecCount++; if (rxQ.size() - rxBase != exp.size()) begin errCount++; $display("[TB] FAIL stall_count: got %0d expected %0d", rxQ.size() - rxBase, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      vecCount++;
      if (rxBase + i >= rxQ.size()) begin errCount++; $display("[TB] FAIL stall_char%0d: got none expected %h", i, exp[i]); end
      else if (rxQ[rxBase + i] !== exp[i]) begin errCount++; $display("[TB] FAIL stall_char%0d: got %h expected %h", i, rxQ[rxBase + i], exp[i]); end
    end
  endtask

  task automatic test_ignore();
    logic [7:0] exp[$];
    exp = '{8'h31, 8'h33, 8'h35, 8'h37, 8'h39, 8'h42, 8'h44, 8'h46, 8'h20};
    clearLine();
    txIf.tx_ready = 1'b1;
    startWord(32'h13579BDF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    // Start while sending hex characters.
    rdataSndStart = 1'b1;
    rdataSnd      = 32'hFFFFFFFF;
    crlfForce     = 1'b1;
    @(negedge clk);
    rdataSndStart = 1'b0;
    repeat (6) @(negedge clk);
    // This cycle is DONE: the flush pulse is high. Start again here.
    vecCount++; if (flushingWq !== 1'b1) begin errCount++; $display("[TB] FAIL ignore_done_flush: got %b expected 1", flushingWq); end
    rdataSndStart = 1'b1;
    rdataSnd      = 32'hEEEEEEEE;
    @(negedge clk);
    rdataSndStart = 1'b0;
    vecCount++; if (busy !== 1'b0) begin errCount++; $display("[TB] FAIL ignore_done_busy: got %b expected 0", busy); end
    repeat (15) @(negedge clk);
    vecCount++; if (flushCount - flushBase != 1) begin errCount++; $display("[TB] FAIL ignore_flush_count: got %0d expected 1", flushCount - flushBase); end
    vecCount++; if (rxQ.size() - rxBase != exp.size()) begin errCount++; $display("[TB] FAIL ignore_count: got %0d expected %0d", rxQ.size() - rxBase, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      vecCount++;
      if (rxBase + i >= rxQ.size()) begin errCount++; $display("[TB] FAIL ignore_char%0d: got none expected %h", i, exp[i]); end
      else if (rxQ[rxBase + i] !== exp[i]) begin errCount++; $display("[TB] FAIL ignore_char%0d: got %h expected %h", i, rxQ[rxBase + i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp[$];
    bit ok;
    int keep;
    txIf.tx_ready = 1'b1;
    startWord(32'h2468ACE0, 1'b0);
    repeat (3) @(negedge clk);
    vecCount++; if (rxQ.size() - rxBase != 3) begin errCount++; $display("[TB] FAIL rstmid_sent_before: got %0d expected 3", rxQ.size() - rxBase); end
    vecCount++; if (txIf.tx_valid !== 1'b1 || txIf.tx_data !== 8'h38) begin errCount++; $display("[TB] FAIL rstmid_char4: got %b/%h expected 1/38", txIf.tx_valid, txIf.tx_data); end
    rst_n = 1'b0;
    #1;
    vecCount++; if (txIf.tx_valid !== 1'b0) begin errCount++; $display("[TB] FAIL rstmid_valid: got %b expected 0", txIf.tx_valid); end
    vecCount++; if (busy !== 1'b0) begin errCount++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
    vecCount++; if (txIf.tx_data !== 8'h00 || flushingWq !== 1'b0) begin errCount++; $display("[TB] FAIL rstmid_outputs: got %h/%b expected 00/0", txIf.tx_data, flushingWq); end
    keep = rxQ.size();
    @(negedge clk);
    rst_n = 1'b1;
    vecCount++; if (dut.r_word_cnt !== 8'd0) begin errCount++; $display("[TB] FAIL rstmid_word_cnt: got %0d expected 0", dut.r_word_cnt); end
    repeat (3) @(negedge clk);
    vecCount++; if (rxQ.size() != keep) begin errCount++; $display("[TB] FAIL rstmid_dropped: got %0d extra expected 0", rxQ.size() - keep); end
    exp = '{8'h43, 8'h41, 8'h46, 8'h45, 8'h46, 8'h30, 8'h30, 8'h44, 8'h20};
    startWord(32'hCAFEF00D, 1'b0);
    waitFlush(ok);
    vecCount++; if (!ok) begin errCount++; $display("[TB] FAIL rstmid_flush_timeout: got none expected pulse"); end
    vecCount++; if (rxQ.size() - rxBase != exp.size()) begin errCount++; $display("[TB] FAIL rstmid_count: got %0d expected %0d", rxQ.size() - rxBase, exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      vecCount++;
      if (rxBase + i >= rxQ.size()) begin errCount++; $display("[TB] FAIL rstmid_char%0d: got none expected %h", i, exp[i]); end
      else if (rxQ[rxBase + i] !== exp[i]) begin errCount++; $display("[TB] FAIL rstmid_char%0d: got %h expected %h", i, rxQ[rxBase + i], exp[i]); end
    end
    vecCount++; if (dut.r_word_cnt !== 8'd1) begin errCount++; $display("[TB] FAIL rstmid_final_cnt: got %0d expected 1", dut.r_word_cnt); end
  endtask

  initial begin
    txIf.tx_ready = 1'b1;
    test_reset();
    test_single();
    test_line_clr();
    test_back_to_back();
    test_force();
    test_stall();
    test_ignore();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
